// File: rtl/display_scan_pkg.sv
// Purpose : shared constants, types and helpers for the 4-digit display scanner.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package display_scan_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [3:0] AN_OFF  = 4'b1111;
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Defaults sized for a 100 MHz core clock.
    localparam int REFRESH_DIV_DEF = 100000;    // 1 kHz digit slot rate
    localparam int BLANK_CYC_DEF   = 16;        // anti-ghosting dead time per slot
    localparam int BLINK_DIV_DEF   = 25000000;  // 2 Hz blink

    typedef logic [1:0] idx_t;

    // Registered display drive: anodes and cathodes, both active-low.
    typedef struct packed {
        logic [3:0] an;
        logic [7:0] seg;
    } disp_t;

    localparam disp_t DISP_OFF = '{an: AN_OFF, seg: SEG_OFF};

    // Active-low one-hot anode enable for the given slot.
    function automatic logic [3:0] an_select(input idx_t idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/display_scan_tick_gen.sv
// Purpose : modulo-N counter with a wrap pulse and a synchronous clear-and-hold.
// Latency : cnt updates on the clock edge; wrap is combinational from cnt/hold.
// Backpressure: none; hold forces the count to 0 and suppresses wrap.
//
// Ports:
//   clk, rst  - clock and asynchronous active-high reset
//   hold      - while high the counter is cleared to 0 and held there
//   cnt       - current count, 0 .. N-1
//   wrap      - high in the cycle where cnt == N-1 and the next edge wraps
module tick_gen #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         hold,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (hold) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign wrap = !hold && (cnt == LAST);

endmodule

// File: rtl/display_scan.sv
// Purpose : time-multiplexed 4-digit 7-segment scanner with per-slot blanking and group blink.
// Latency : every output change appears exactly 1 cycle after its cause (an/seg are registered).
// Backpressure: none; free-running, inputs are sampled every cycle.
//
// Ports:
//   clk, rst                  - clock and asynchronous active-high reset
//   digit0..3_display [7:0]   - active-low {dp,g..a}; digit0 rightmost, digit3 leftmost
//   blink_en                  - adjust mode: selected group blinks
//   blink_sel                 - 0: seconds group (digits 0,1); 1: minutes group (digits 2,3)
//   an [3:0]                  - active-low anode enables, an[i] drives digit i
//   seg [7:0]                 - active-low cathodes, same bit order as digitN_display
module display_scan
    import display_scan_pkg::*;
#(
    parameter int REFRESH_DIV = REFRESH_DIV_DEF,
    parameter int BLANK_CYC   = BLANK_CYC_DEF,
    parameter int BLINK_DIV   = BLINK_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] digit0_display,
    input  logic [7:0] digit1_display,
    input  logic [7:0] digit2_display,
    input  logic [7:0] digit3_display,
    input  logic       blink_en,
    input  logic       blink_sel,
    output logic [3:0] an,
    output logic [7:0] seg
);

    localparam int RW = $clog2(REFRESH_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [RW-1:0] BLANK_LIM = RW'(BLANK_CYC);

    logic [RW-1:0] rc;
    logic          rc_wrap;
    logic [BW-1:0] bc;
    logic          bc_wrap;
    idx_t          idx;
    logic          blink_phase;

    logic [7:0]    digit_sel;
    logic          blank;
    logic          dark;
    disp_t         disp_nxt;
    disp_t         disp_q;

    // Slot timer: runs continuously.
    tick_gen #(
        .N (REFRESH_DIV),
        .W (RW)
    ) u_refresh (
        .clk  (clk),
        .rst  (rst),
        .hold (1'b0),
        .cnt  (rc),
        .wrap (rc_wrap)
    );

    // Blink timer: parked at 0 outside adjust mode so each new adjust
    // session starts with a full visible half-period.
    tick_gen #(
        .N (BLINK_DIV),
        .W (BW)
    ) u_blink (
        .clk  (clk),
        .rst  (rst),
        .hold (!blink_en),
        .cnt  (bc),
        .wrap (bc_wrap)
    );

    // Slot index and blink phase. idx is two bits wide so 3 -> 0 wraps
    // naturally. Both counters are independent, so a refresh wrap and a
    // blink wrap on the same edge each take effect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx         <= '0;
            blink_phase <= 1'b0;
        end else begin
            if (rc_wrap) begin
                idx <= idx + 1'b1;
            end
            if (!blink_en) begin
                blink_phase <= 1'b0;
            end else if (bc_wrap) begin
                blink_phase <= ~blink_phase;
            end
        end
    end

    // Next display word. blink_en gates the dark decision directly so that
    // digits reappear on the very next update after adjust mode ends.
    always_comb begin
        digit_sel = digit0_display;
        unique case (idx)
            2'd0: digit_sel = digit0_display;
            2'd1: digit_sel = digit1_display;
            2'd2: digit_sel = digit2_display;
            2'd3: digit_sel = digit3_display;
        endcase

        blank = (rc < BLANK_LIM);
        // idx[1] distinguishes the minutes group (2,3) from seconds (0,1).
        dark  = blink_en && blink_phase && (idx[1] == blink_sel);

        disp_nxt = DISP_OFF;
        if (!blank && !dark) begin
            disp_nxt = '{an: an_select(idx), seg: digit_sel};
        end
    end

    // Output register: no combinational path from any input to an/seg.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_q <= DISP_OFF;
        end else begin
            disp_q <= disp_nxt;
        end
    end

    assign an  = disp_q.an;
    assign seg = disp_q.seg;

    // Blink timer must stay parked while adjust mode is off.
    a_blink_parked: assert property (@(posedge clk) disable iff (rst)
        !blink_en |=> (bc == '0));

    // Never drive more than one digit at once.
    a_an_onehot: assert property (@(posedge clk) disable iff (rst)
        $countones(~an) <= 1);

endmodule

// File: tb/tb_display_scan.sv
// Purpose : randomized scoreboard bench for display_scan against an edge-count reference model.
// Latency : expects each output 1 cycle after the inputs sampled on an edge.
// Backpressure: n/a.
module tb_display_scan;

    localparam int R  = 8;   // REFRESH_DIV
    localparam int BL = 2;   // BLANK_CYC
    localparam int B  = 20;  // BLINK_DIV

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] d [4];
    logic       blink_en;
    logic       blink_sel;
    logic [3:0] an;
    logic [7:0] seg;

    int n_tests = 0;
    int n_fail  = 0;

    logic [11:0] exp_q [$];

    // Reference model state: edges since reset release, and consecutive
    // edges with blink_en sampled high.
    int k_edges = 0;
    int j_blink = 0;
    int m_rc, m_slot;
    bit m_ph, m_grp;

    display_scan #(
        .REFRESH_DIV (R),
        .BLANK_CYC   (BL),
        .BLINK_DIV   (B)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .digit0_display (d[0]),
        .digit1_display (d[1]),
        .digit2_display (d[2]),
        .digit3_display (d[3]),
        .blink_en       (blink_en),
        .blink_sel      (blink_sel),
        .an             (an),
        .seg            (seg)
    );

    always #5 clk = ~clk;

    // Reference model: the slot position is a pure function of the number
    // of edges since reset; the blink phase is a pure function of how long
    // blink_en has been continuously high.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.push_back({4'hF, 8'hFF});
            k_edges = 0;
            j_blink = 0;
        end else begin
            m_rc   = k_edges % R;
            m_slot = (k_edges / R) % 4;
            m_ph   = blink_en && (((j_blink / B) % 2) == 1);
            m_grp  = ((m_slot >= 2) == blink_sel);
            if (m_rc < BL || (m_ph && m_grp))
                exp_q.push_back({4'hF, 8'hFF});
            else
                exp_q.push_back({4'hF & ~(4'b0001 << m_slot), d[m_slot]});
            k_edges = k_edges + 1;
            j_blink = blink_en ? j_blink + 1 : 0;
        end
    end

    // Monitor: pops one expectation per edge and checks the one-hot rule.
    initial begin
        logic [11:0] exp;
        forever begin
            @(posedge clk);
            #1;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty at %0t: an=%b seg=%h, no expectation queued", $time, an, seg);
            end else begin
                exp = exp_q.pop_front();
                if ({an, seg} !== exp) begin
                    n_fail++;
                    $display("FAIL output at %0t: got an=%b seg=%h, required an=%b seg=%h",
                             $time, an, seg, exp[11:8], exp[7:0]);
                end
            end
            n_tests++;
            if ($countones(~an) > 1) begin
                n_fail++;
                $display("FAIL an_onehot at %0t: got an=%b, required at most one low bit", $time, an);
            end
        end
    end

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    task automatic check_off(input string name);
        n_tests++;
        if (an !== 4'b1111 || seg !== 8'hFF) begin
            n_fail++;
            $display("FAIL %s: got an=%b seg=%h, required an=1111 seg=ff", name, an, seg);
        end
    endtask

    // Wait (at negedges) until the next edge will be at the given slot/rc.
    task automatic wait_slot(input int slot, input int rc, input string name);
        bit hit = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if ((k_edges / R) % 4 == slot && k_edges % R == rc) begin
                hit = 1;
                break;
            end
        end
        if (!hit) timeout(name);
    endtask

    initial begin
        bit hit;
        blink_en  = 1'b0;
        blink_sel = 1'b0;
        d[0] = 8'hC0; d[1] = 8'hF9; d[2] = 8'hA4; d[3] = 8'hB0;

        // Asynchronous reset without any clock edge.
        #1 rst = 1'b1;
        #1 check_off("reset_async");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Plain scan across several full rotations.
        repeat (40) @(negedge clk);

        // Minutes group blinking.
        blink_sel = 1'b1;
        blink_en  = 1'b1;
        repeat (100) @(negedge clk);

        // Drop adjust mode in the middle of a dark half-period.
        hit = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (((j_blink / B) % 2) == 1 && (j_blink % B) == 5) begin
                hit = 1;
                break;
            end
        end
        if (!hit) timeout("wait_dark_phase");
        blink_en = 1'b0;
        repeat (10) @(negedge clk);
        blink_en = 1'b1;
        repeat (60) @(negedge clk);

        // Digit change in the middle of slot 2.
        blink_en = 1'b0;
        repeat (2) @(negedge clk);
        wait_slot(2, 4, "wait_slot2");
        d[2] = 8'h92;
        @(posedge clk);
        #2;
        n_tests++;
        if (an !== 4'b1011 || seg !== 8'h92) begin
            n_fail++;
            $display("FAIL digit_change: got an=%b seg=%h, required an=1011 seg=92", an, seg);
        end
        repeat (12) @(negedge clk);

        // Random inputs.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 49) == 0) blink_en = ~blink_en;
            if ($urandom_range(0, 29) == 0) blink_sel = ~blink_sel;
            if ($urandom_range(0, 3) == 0) d[$urandom_range(0, 3)] = 8'($urandom);
        end

        // Reset pulse between edges while slot 3 is lit and blink is active.
        d[0] = 8'hC0; d[1] = 8'hF9; d[2] = 8'hA4; d[3] = 8'hB0;
        blink_en  = 1'b1;
        blink_sel = 1'b0;
        wait_slot(3, 5, "wait_slot3");
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_off("reset_mid_slot");
        @(negedge clk);
        rst      = 1'b0;
        blink_en = 1'b0;
        repeat (40) @(negedge clk);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
